// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous FIFO: read pointer, empty/level flags, registered read data.
// Optional FIFO_RD_TRISTATE_EN: dout driven high-Z whenever dout_valid is low (shared read bus).
`default_nettype none

module fifo_read_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AE_THRESH = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              dout_valid_reg, dout_valid_next;
    logic              underflow_reg, underflow_next;
    logic [ADDR_W:0]   level_cur;
    logic              empty_cur;
    logic              rd_accept;

    // Wrap-bit pointers: the modular difference is the occupancy, 0..2^ADDR_W.
    assign level_cur = wr_ptr - rd_ptr_reg;
    assign empty_cur = (level_cur == '0);
    assign rd_accept = rd_en && !empty_cur;

    always_comb begin
        rd_ptr_next     = rd_ptr_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        underflow_next  = 1'b0;
        if (rd_accept) begin
            rd_ptr_next     = rd_ptr_reg + PTR_ONE;
            dout_next       = mem_rdata;
            dout_valid_next = 1'b1;
        end else if (rd_en) begin
            underflow_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            rd_ptr_reg     <= rd_ptr_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            underflow_reg  <= underflow_next;
        end
    end

    assign mem_addr     = rd_ptr_reg[ADDR_W-1:0];
    assign rd_ptr       = rd_ptr_reg;
    assign dout_valid   = dout_valid_reg;
    assign underflow    = underflow_reg;
    assign level        = level_cur;
    assign empty        = empty_cur;
    assign almost_empty = (level_cur <= AE_THRESH);

`ifdef FIFO_RD_TRISTATE_EN
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_dout_tri
            assign dout[gi] = dout_valid_reg ? dout_reg[gi] : 1'bz;
        end
    endgenerate
`else
    assign dout = dout_reg;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's synchronous FIFO: the consumer end of the pointer scheme whose write side advances a 5-bit wrap-bit pointer through the ripple-carry adder. It owns the read pointer, gates read requests against empty, addresses the storage array and registers the read data. It also reports occupancy, almost-empty and underflow to the consumer. It sits between the FIFO memory array and the downstream consumer, in the same clock domain as the write controller.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 4, memory address width; pointers are ADDR_W+1 bits; depth = 2^ADDR_W = 16
- AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_ptr  input  ADDR_W+1  write pointer from write controller, registered in clk domain
- rd_en  input  1  consumer read request
- mem_rdata  input  DATA_W  array data at mem_addr (combinational array read)
- mem_addr  output  ADDR_W  array read address = rd_ptr[ADDR_W-1:0]
- rd_ptr  output  ADDR_W+1  read pointer, fed back to write controller for full detection
- dout  output  DATA_W  registered read data
- dout_valid  output  1  dout holds a fresh word this cycle
- empty  output  1  rd_ptr == wr_ptr
- almost_empty  output  1  level <= AE_LEVEL
- level  output  ADDR_W+1  occupancy, 0..16
- underflow  output  1  one-cycle pulse: read attempted while empty

## Operation
- Accepted read: rd_en && !empty, evaluated combinationally from the current rd_ptr and wr_ptr.
- On an accepted read at edge N: dout <= mem_rdata at mem_addr; dout_valid <= 1; rd_ptr <= rd_ptr + 1, modulo 2^(ADDR_W+1), so 31 -> 0 with the wrap bit toggling.
- Rejected read (rd_en && empty): rd_ptr and dout are unchanged, dout_valid <= 0, underflow <= 1 for one cycle.
- No request: dout_valid <= 0, dout holds its last value, underflow <= 0.
- level = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1). Combinational from registered rd_ptr and input wr_ptr; no saturation needed because the write side guarantees level <= 16.
- empty = (level == 0); almost_empty = (level <= AE_LEVEL). Empty implies almost_empty.
- Simultaneous write and read: wr_ptr updates in the write controller and rd_ptr updates here at the same edge, so level is unchanged. A read is not accepted against a word written in the same cycle, because empty is evaluated on the pre-edge wr_ptr.
- Full (level == 16): reads are accepted normally. Full detection belongs to the write side.
- State: rd_ptr, dout, dout_valid, underflow registers only. There is no FSM beyond the pointer.

## Timing
- Reset (asynchronous, immediate): rd_ptr = 0, dout = 0, dout_valid = 0, underflow = 0. Combinational outputs follow: mem_addr = 0, and empty, almost_empty and level track wr_ptr.
- Reset asserted mid-stream aborts the in-flight read: dout_valid drops in the same cycle, without waiting for a clock edge. The write controller is reset by the same rst.
- Read latency is 1 cycle: rd_en is sampled at edge N, and dout/dout_valid are valid after edge N until edge N+1.
- Back-to-back: rd_en held high with level >= k yields k consecutive dout_valid cycles with no bubbles.
- underflow is asserted exactly in the cycle after the rejected request. Repeated rejected requests give a continuous high.

## Configuration
- FIFO_RD_TRISTATE_EN defined: dout is driven through per-bit tristate buffers enabled by dout_valid, so it is high-Z whenever dout_valid = 0, including during reset. This allows several FIFOs to share a read bus.
- Not defined: dout is always driven and holds its last registered value. The reset value is 0.

## Test plan
- Reset then idle, with wr_ptr = 0: empty = 1, almost_empty = 1, level = 0, dout_valid = 0, underflow = 0, rd_ptr = 0.
- Underflow: wr_ptr = 0, rd_en for 2 cycles -> underflow high for 2 cycles, rd_ptr stays 0, no dout_valid.
- Single read: array holds 0xA5 at address 0, wr_ptr = 1, one-cycle rd_en -> next cycle dout = 0xA5, dout_valid = 1; then rd_ptr = 1, empty = 1.
- Wrap: preload rd_ptr = wr_ptr = 14 (via write traffic), write 4 words so wr_ptr = 18, read 4 back-to-back -> data from addresses 14, 15, 0, 1 in order, rd_ptr = 18, empty = 1. Repeat until rd_ptr passes 31 -> 0 and check level stays correct.
- Full and almost-empty: wr_ptr = 16, rd_ptr = 0 -> level = 16, empty = 0. Read 14 words -> almost_empty rises on the cycle level becomes 2.
- Async reset mid-burst: assert rst between edges during a back-to-back read -> dout_valid = 0 and rd_ptr = 0 immediately. With FIFO_RD_TRISTATE_EN, dout = Z; without it, dout = 0.
